// File: rtl/axis_read_unpack.sv
// axis_read_unpack: buffers wide AXI read beats in a small FIFO and emits
// each beat as WIDTH_RATIO narrow stream words, lane 0 first. Supports a
// start-lane offset in the first beat, trims unused lanes of the final beat
// and flags the final word with last.
module axis_read_unpack #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CFG_DWIDTH     = 32,
  parameter int WIDTH_RATIO    = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_W         = $clog2(WIDTH_RATIO)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic [LANE_W-1:0]         cfg_offset,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      last
);

  localparam int DEPTH = 1 << BUF_AWIDTH;
  localparam int CNT_W = BUF_AWIDTH + 1;
  localparam int BL_W  = CFG_DWIDTH + 2;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e                    state_q;
  logic                      cfg_rdy_q;
  logic [CFG_DWIDTH-1:0]     remaining_q;
  logic [LANE_W-1:0]         lane_q;
  logic [BL_W-1:0]           beats_left_q;
  logic [BL_W-1:0]           span;

  logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [BUF_AWIDTH-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]          count_q, count_d;

  logic fifo_full, fifo_empty, push, pop, word_acc, final_word, cfg_acc;

  // offset + length + (ratio-1) is carried two bits wider than the length so
  // the round-up to whole beats can never wrap.
  assign span = {2'b00, cfg_length} + BL_W'(cfg_offset) + BL_W'(WIDTH_RATIO - 1);

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  assign cfg_rdy    = cfg_rdy_q;
  assign cfg_acc    = (state_q == ST_IDLE) & cfg_rdy_q & cfg_val;
  assign axi_rready = (state_q == ST_ACTIVE) & ~fifo_full & (beats_left_q != '0);
  assign push       = axi_rvalid & axi_rready;

  assign valid      = (state_q == ST_ACTIVE) & ~fifo_empty;
  assign final_word = (remaining_q == CFG_DWIDTH'(1));
  assign last       = valid & final_word;
  assign word_acc   = valid & ready;
  // Popping on the final word drops any trailing lanes of the last beat.
  assign pop        = word_acc & ((lane_q == LANE_W'(WIDTH_RATIO - 1)) | final_word);
  assign data       = valid ? mem_q[rptr_q][lane_q*DATA_WIDTH +: DATA_WIDTH] : '0;

  // Control FSM: configuration latch, beat budget, word/lane counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_rdy_q    <= 1'b0;
      remaining_q  <= '0;
      lane_q       <= '0;
      beats_left_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cfg_rdy_q <= 1'b1;
      if (cfg_acc) begin
        remaining_q  <= cfg_length;
        lane_q       <= cfg_offset;
        beats_left_q <= span >> LANE_W;
        if (cfg_length != '0) begin
          state_q   <= ST_ACTIVE;
          cfg_rdy_q <= 1'b0;
        end
      end
    end else begin
      if (push) beats_left_q <= beats_left_q - BL_W'(1);
      if (word_acc) begin
        remaining_q <= remaining_q - CFG_DWIDTH'(1);
        lane_q      <= lane_q + LANE_W'(1);
        if (final_word) begin
          state_q   <= ST_IDLE;
          cfg_rdy_q <= 1'b1;
        end
      end
    end
  end

  // FIFO occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and registered occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + BUF_AWIDTH'(1);
      if (pop)  rptr_q <= rptr_q + BUF_AWIDTH'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents need no reset since reads are gated by valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= axi_rdata;
  end

endmodule

// File: tb/tb_axis_read_unpack.sv
module tb_axis_read_unpack;

  logic         clk;
  logic         rst_n;
  logic [31:0]  cfg_length;
  logic [2:0]   cfg_offset;
  logic         cfg_val;
  logic         cfg_rdy;
  logic [255:0] axi_rdata;
  logic         axi_rvalid;
  logic         axi_rready;
  logic [31:0]  data;
  logic         valid;
  logic         ready;
  logic         last;

  axis_read_unpack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_length (cfg_length),
    .cfg_offset (cfg_offset),
    .cfg_val    (cfg_val),
    .cfg_rdy    (cfg_rdy),
    .axi_rdata  (axi_rdata),
    .axi_rvalid (axi_rvalid),
    .axi_rready (axi_rready),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .last       (last)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [255:0] beat_q[$];
  logic [255:0] new_beats[$];
  logic [32:0]  exp_q[$];

  int beats_acc = 0;
  int word_cnt  = 0;
  int ready_pct = 100;
  int bubbles   = 0;
  bit bubble_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] mk_beat(int base);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = 32'(base + i);
    return b;
  endfunction

  function automatic logic [255:0] rnd_beat();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Upstream AXI source: presents queued beats, pops on handshake.
  initial begin
    bit acc;
    axi_rvalid = 0;
    axi_rdata  = '0;
    forever begin
      @(negedge clk);
      acc = axi_rvalid && axi_rready;
      @(posedge clk);
      #1;
      if (acc && rst_n && beat_q.size() > 0) begin
        void'(beat_q.pop_front());
        beats_acc++;
      end
      axi_rvalid = (beat_q.size() > 0);
      axi_rdata  = axi_rvalid ? beat_q[0] : '0;
    end
  end

  // Downstream ready generator.
  initial begin
    ready = 0;
    forever begin
      @(posedge clk);
      #1;
      ready = ($urandom_range(99, 0) < ready_pct);
    end
  end

  // Output monitor and scoreboard comparison.
  initial begin
    bit          stall;
    bit          rdy_pend;
    logic [32:0] prev;
    logic [32:0] e;
    stall = 0;
    rdy_pend = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
        rdy_pend = 0;
      end else begin
        if (rdy_pend) begin
          chk("cfg_rdy_after_last", cfg_rdy, 1);
          rdy_pend = 0;
        end
        if (stall) begin
          chk("hold_valid", valid, 1);
          chk("hold_word", {last, data}, prev);
        end
        if (valid && ready) begin
          word_cnt++;
          chk("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("word", {last, data}, e);
            if (last) begin
              chk("cfg_rdy_during_last", cfg_rdy, 0);
              rdy_pend = 1;
            end
          end
        end
        if (bubble_en && ready && !valid && exp_q.size() > 0) bubbles++;
        stall = valid && !ready;
        prev  = {last, data};
      end
    end
  end

  // Builds expected words from the beats, queues beats, then handshakes the config.
  task automatic start_xfer(input int len, input int off, input bit push_beats);
    logic [255:0] b[$];
    logic [255:0] cur;
    int n, p;
    bit got;
    n = (off + len + 7) / 8;
    if (len == 0) n = 0;
    b = new_beats;
    new_beats.delete();
    while (b.size() < n) b.push_back(rnd_beat());
    for (int i = 0; i < len; i++) begin
      p   = off + i;
      cur = b[p / 8];
      exp_q.push_back({(i == len - 1), cur[(p % 8)*32 +: 32]});
    end
    if (push_beats) for (int k = 0; k < n; k++) beat_q.push_back(b[k]);
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (cfg_rdy) got = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("cfg_rdy_wait", got, 1);
    cfg_val    = 1;
    cfg_length = 32'(len);
    cfg_offset = 3'(off);
    @(posedge clk);
    #1;
    cfg_val = 0;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 0;
    for (int c = 0; c < limit && !done; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && cfg_rdy) done = 1;
    end
    chk("idle_wait", done, 1);
  endtask

  task automatic scenario1();
    int b0;
    b0 = beats_acc;
    ready_pct = 100;
    new_beats.push_back(mk_beat(1));
    new_beats.push_back(mk_beat(2));
    start_xfer(10, 0, 1);
    wait_idle(200);
    chk("s1_beats", beats_acc - b0, 2);
    chk("s1_rready_after", axi_rready, 0);
  endtask

  initial begin
    logic [255:0] b;
    int b0, w0;
    rst_n = 0;
    cfg_val = 0;
    cfg_length = '0;
    cfg_offset = '0;
    #1;
    chk("rst_cfg_rdy", cfg_rdy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_last", last, 0);
    chk("rst_data", data, 0);
    #21 rst_n = 1;
    #2 chk("cfg_rdy_before_edge", cfg_rdy, 0);
    @(posedge clk);
    #1;
    chk("cfg_rdy_first_edge", cfg_rdy, 1);

    scenario1();

    new_beats.push_back(mk_beat(1));
    new_beats.push_back(mk_beat(9));
    b0 = beats_acc;
    start_xfer(6, 3, 1);
    wait_idle(200);
    chk("s2_beats", beats_acc - b0, 2);

    ready_pct = 0;
    b0 = beats_acc;
    start_xfer(200, 0, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("s3_beats_full", beats_acc - b0, 16);
    chk("s3_rready_full", axi_rready, 0);
    chk("s3_valid_held", valid, 1);
    bubbles = 0;
    bubble_en = 1;
    ready_pct = 100;
    wait_idle(400);
    bubble_en = 0;
    chk("s3_bubbles", bubbles, 0);
    chk("s3_beats_total", beats_acc - b0, 25);

    b = rnd_beat();
    b[7*32 +: 32] = 32'hA5;
    beat_q.push_back(b);
    start_xfer(0, 3, 0);
    for (int i = 0; i < 6; i++) begin
      chk("s4_cfg_rdy", cfg_rdy, 1);
      chk("s4_rready", axi_rready, 0);
      chk("s4_valid", valid, 0);
      @(posedge clk);
      #1;
    end
    chk("s4_beat_untouched", beat_q.size(), 1);
    new_beats.push_back(b);
    start_xfer(1, 7, 0);
    wait_idle(100);
    chk("s4_beat_used", beat_q.size(), 0);

    w0 = word_cnt;
    ready_pct = 100;
    new_beats.push_back(mk_beat(1));
    new_beats.push_back(mk_beat(2));
    start_xfer(10, 0, 1);
    for (int c = 0; c < 100 && word_cnt < w0 + 5; c++) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("s5_valid", valid, 0);
    chk("s5_data", data, 0);
    chk("s5_last", last, 0);
    chk("s5_rready", axi_rready, 0);
    chk("s5_cfg_rdy", cfg_rdy, 0);
    beat_q.delete();
    exp_q.delete();
    axi_rvalid = 0;
    #20 rst_n = 1;
    @(posedge clk);
    #1;
    chk("s5_cfg_rdy_release", cfg_rdy, 1);
    scenario1();

    for (int t = 0; t < 50; t++) begin
      ready_pct = $urandom_range(100, 30);
      start_xfer($urandom_range(40, 1), $urandom_range(7, 0), 1);
    end
    wait_idle(20000);
    chk("s6_beats_drained", beat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
